noise_table_loader: RTL and testbench

- Writer side of the noise sample table. The noise path reads one 32-bit sample per cycle from this table, multiplies it by a Q8.24 scale, keeps product bits [55:24], and adds the offset.
- This block takes a new noise table from a 32-bit AXI-Stream and writes it into the inactive half of a double-buffered BRAM.
- When loading completes, it hands the new half to the reader at a reader-safe boundary.

---
 rtl/noise_pkg.sv | 9 +
 rtl/noise_bank_ctrl.sv | 19 +
 rtl/noise_table_loader.sv | 87 ++++++++
 tb/tb_noise_table_loader.sv | 173 +++++++++++++++++
 4 files changed

// File: rtl/noise_pkg.sv
// noise_pkg: shared widths, Q8.24 scale constants and loader state encoding for the noise path.
package noise_pkg;
    localparam int NOISE_DATA_W = 32;
    localparam int NOISE_ADDR_W = 10;
    localparam int SCALE_FRAC   = 24;
    localparam int SLICE_MSB    = 55;
    localparam int SLICE_LSB    = 24;
    typedef enum logic [1:0] {ST_IDLE, ST_LOAD, ST_WAIT_SWAP} state_t;
endpackage

// File: rtl/noise_bank_ctrl.sv
// noise_bank_ctrl: owns the reader's bank select and flips it only at a reader-safe wrap point.
module noise_bank_ctrl (
    input  logic clk,
    input  logic rst_n,
    input  logic swap_req,
    input  logic swap_ok,
    output logic active_bank,
    output logic done
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_bank <= 1'b0;
            done        <= 1'b0;
        end else begin
            done <= swap_req & swap_ok;
            if (swap_req & swap_ok) active_bank <= ~active_bank;
        end
    end
endmodule

// File: rtl/noise_table_loader.sv
// noise_table_loader: streams a new noise table into the inactive BRAM bank, then
// hands it to the reader via noise_bank_ctrl.
module noise_table_loader
    import noise_pkg::*;
#(
    parameter int DATA_W = NOISE_DATA_W,
    parameter int ADDR_W = NOISE_ADDR_W
) (
    input  logic              CLK,
    input  logic              RESETN,
    input  logic              start,
    input  logic [ADDR_W:0]   length,
    input  logic [DATA_W-1:0] s_tdata,
    input  logic              s_tvalid,
    input  logic              s_tlast,
    output logic              s_tready,
    input  logic              swap_ok,
    output logic              bram_en,
    output logic              bram_we,
    output logic [ADDR_W:0]   bram_addr,
    output logic [DATA_W-1:0] bram_din,
    output logic              active_bank,
    output logic              busy,
    output logic              done,
    output logic              err_len
);
    localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};

    state_t            state;
    logic [ADDR_W-1:0] index;
    logic [ADDR_W:0]   len_q;
    logic              beat, last_idx, len_ok;

    assign s_tready  = state == ST_LOAD;
    assign busy      = state != ST_IDLE;
    assign beat      = s_tvalid & s_tready;
    assign last_idx  = {1'b0, index} == len_q - 1'b1;
    assign len_ok    = length != '0 && length <= DEPTH;
    // Write port is combinational from the beat; address/data are zeroed when idle.
    assign bram_en   = beat;
    assign bram_we   = beat;
    assign bram_addr = beat ? {~active_bank, index} : '0;
    assign bram_din  = beat ? s_tdata : '0;

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state   <= ST_IDLE;
            index   <= '0;
            len_q   <= '0;
            err_len <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start && len_ok) begin
                        len_q   <= length;
                        index   <= '0;
                        err_len <= 1'b0;
                        state   <= ST_LOAD;
                    end else if (start) begin
                        err_len <= 1'b1;
                    end
                end
                ST_LOAD: begin
                    if (beat) begin
                        if (last_idx || s_tlast) begin
                            state <= ST_WAIT_SWAP;
                            if (last_idx != s_tlast) err_len <= 1'b1;
                        end else begin
                            index <= index + 1'b1;
                        end
                    end
                end
                ST_WAIT_SWAP: if (swap_ok) state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    noise_bank_ctrl u_bank (
        .clk        (CLK),
        .rst_n      (RESETN),
        .swap_req   (state == ST_WAIT_SWAP),
        .swap_ok    (swap_ok),
        .active_bank(active_bank),
        .done       (done)
    );
endmodule

// File: tb/tb_noise_table_loader.sv
// tb_noise_table_loader: table-driven loads with a write scoreboard, plus swap-wait,
// bad-length and reset-abort sequences.
module tb_noise_table_loader;
    logic        CLK, RESETN, start, s_tvalid, s_tlast, s_tready, swap_ok;
    logic [10:0] length, bram_addr;
    logic [31:0] s_tdata, bram_din;
    logic        bram_en, bram_we, active_bank, busy, done, err_len;

    noise_table_loader dut (
        .CLK(CLK), .RESETN(RESETN), .start(start), .length(length),
        .s_tdata(s_tdata), .s_tvalid(s_tvalid), .s_tlast(s_tlast), .s_tready(s_tready),
        .swap_ok(swap_ok), .bram_en(bram_en), .bram_we(bram_we), .bram_addr(bram_addr),
        .bram_din(bram_din), .active_bank(active_bank), .busy(busy), .done(done),
        .err_len(err_len)
    );

    typedef struct {
        int          len;
        int          nbeats;
        int          tlast_at;
        bit          gap;
        bit          exp_err;
        logic [31:0] d0;
    } vec_t;

    vec_t        vecs[5];
    logic [43:0] q[$];
    int          n_checks = 0, n_fail = 0, writes = 0;
    bit          exp_bank = 1'b0;

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Scoreboard: every BRAM write must match the oldest expected {en, addr, data}.
    always @(negedge CLK) begin
        if (bram_we) begin
            writes++;
            if (q.size() == 0) chk("unexpected_write", {1'b1, bram_addr, bram_din}, 44'h0);
            else chk("bram_write", {bram_en, bram_addr, bram_din}, q.pop_front());
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic run_case(input vec_t v, input bit hold_swap);
        swap_ok = hold_swap;
        start   = 1'b1;
        length  = 11'(v.len);
        step();
        start = 1'b0;
        chk("start_clears_err", err_len, 1'b0);
        chk("load_busy", busy, 1'b1);
        chk("load_tready", s_tready, 1'b1);
        writes = 0;
        for (int i = 0; i < v.nbeats; i++) begin
            if (v.gap && i > 0) begin
                s_tvalid = 1'b0;
                step();
            end
            s_tvalid = 1'b1;
            s_tdata  = (i == 0) ? v.d0 : 32'(i);
            s_tlast  = (i == v.tlast_at);
            q.push_back({1'b1, ~exp_bank, 10'(i), s_tdata});
            step();
        end
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        chk("wait_tready", s_tready, 1'b0);
        chk("wait_busy", busy, 1'b1);
        chk("err_len", err_len, v.exp_err);
        chk("write_count", writes, v.nbeats);
        chk("queue_empty", q.size(), 0);
        if (hold_swap) begin
            step();
            exp_bank = ~exp_bank;
            chk("swap_done", done, 1'b1);
            chk("swap_bank", active_bank, exp_bank);
            chk("swap_idle", busy, 1'b0);
            step();
            chk("done_one_cycle", done, 1'b0);
        end
    endtask

    initial begin
        vecs[0] = '{4, 4, 3, 1'b0, 1'b0, 32'h0000_1229};
        vecs[1] = '{4, 4, 3, 1'b1, 1'b0, 32'hA5A5_0000};
        vecs[2] = '{8, 3, 2, 1'b0, 1'b1, 32'h0BAD_0001};
        vecs[3] = '{3, 3, -1, 1'b0, 1'b1, 32'h0000_0300};
        vecs[4] = '{1, 1, 0, 1'b0, 1'b0, 32'hFFFF_FFFF};
        RESETN = 1'b0; start = 1'b0; length = '0; s_tdata = '0;
        s_tvalid = 1'b0; s_tlast = 1'b0; swap_ok = 1'b0;
        step(); step();
        chk("rst_outputs", {s_tready, bram_en, bram_we, bram_addr, bram_din, active_bank, busy, done, err_len}, '0);
        RESETN = 1'b1;
        step();

        // Out-of-range lengths are rejected and flag err_len.
        start = 1'b1; length = 11'd0;
        step();
        start = 1'b0;
        chk("len0_err", err_len, 1'b1);
        chk("len0_idle", busy, 1'b0);
        start = 1'b1; length = 11'd1025;
        step();
        start = 1'b0;
        chk("len1025_idle", busy, 1'b0);
        chk("len1025_err", err_len, 1'b1);

        foreach (vecs[k]) run_case(vecs[k], 1'b1);

        // Swap held off for 10 cycles; stray start and stream beats must be ignored.
        run_case('{2, 2, 1, 1'b0, 1'b0, 32'h0000_2222}, 1'b0);
        start = 1'b1; length = 11'd5; s_tvalid = 1'b1; s_tdata = 32'hDEAD_BEEF;
        for (int c = 0; c < 10; c++) begin
            step();
            start = 1'b0;
            chk("hold_busy", busy, 1'b1);
            chk("hold_tready", s_tready, 1'b0);
            chk("hold_done", done, 1'b0);
            chk("hold_bank", active_bank, exp_bank);
        end
        s_tvalid = 1'b0;
        swap_ok = 1'b1;
        step();
        swap_ok = 1'b0;
        exp_bank = ~exp_bank;
        chk("late_swap_done", done, 1'b1);
        chk("late_swap_bank", active_bank, exp_bank);
        step();
        chk("late_done_once", done, 1'b0);
        chk("late_idle", busy, 1'b0);
        chk("busy_start_no_err", err_len, 1'b0);

        // Reset after two of four beats aborts and returns to bank 0.
        swap_ok = 1'b1; start = 1'b1; length = 11'd4;
        step();
        start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            s_tvalid = 1'b1;
            s_tdata  = 32'h7000_0000 + 32'(i);
            q.push_back({1'b1, ~exp_bank, 10'(i), s_tdata});
            step();
        end
        s_tvalid = 1'b0;
        RESETN = 1'b0;
        #1;
        chk("abort_bank", active_bank, 1'b0);
        chk("abort_idle", busy, 1'b0);
        chk("abort_we", bram_we, 1'b0);
        chk("abort_done", done, 1'b0);
        chk("abort_queue", q.size(), 0);
        exp_bank = 1'b0;
        step();
        chk("abort_done_hold", done, 1'b0);
        RESETN = 1'b1;
        step();
        run_case('{1, 1, 0, 1'b0, 1'b0, 32'h0000_0400}, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
